next_pc_predictor: RTL and testbench

//  Fetch-stage PC generator with dynamic branch prediction.
//  - Owns the PC register and predicts each fetch from a direct-mapped table: 2-bit BHT counter plus BTB target/tag.
//  - Resolves branch/JAL/JALR outcomes reported by EX and redirects/flushes on mispredict.
//  - Handles ECALL (to mtvec) and MRET (to mepc).
//  - Successor to the combinational branch mux: adds registered PC, prediction state and stall handling.

---
 rtl/pc_pkg.sv | 35 +++
 rtl/bht_btb.sv | 90 +++++++++
 rtl/next_pc_predictor.sv | 166 ++++++++++++++++
 tb/tb_next_pc_predictor.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Package : pc_pkg
//  Purpose : Shared types and helpers for the fetch-stage PC predictor.
//            Branch funct3 encodings, the 2-bit saturating counter type
//            and its reset/limit values, and the counter step function.
//  Revision: 1.0 - initial release
// ============================================================================
package pc_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_RESET = 2'b01;   // weak not-taken
    localparam cnt_t CNT_MAX   = 2'b11;   // strong taken
    localparam cnt_t CNT_MIN   = 2'b00;   // strong not-taken

    // Saturating up/down step of a 2-bit branch history counter.
    function automatic cnt_t cnt_step(input cnt_t cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_MAX) ? CNT_MAX : cnt + 2'b01;
        end
        return (cnt == CNT_MIN) ? CNT_MIN : cnt - 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_btb.sv
`default_nettype none
// ============================================================================
//  Module  : bht_btb
//  Purpose : Direct-mapped prediction table. Each entry holds a 2-bit branch
//            history counter, a BTB valid bit, a tag and a target address.
//            One combinational read port, one synchronous update port.
//  Ports   : clk, rst            clock, async active-high reset
//            rd_idx              lookup index
//            rd_valid/tag/cnt/tgt  entry contents at rd_idx (old value on a
//                                same-cycle update; no bypass)
//            upd_en              update the entry at upd_idx this edge
//            upd_branch          conditional branch: step counter by upd_taken
//            upd_jump            jump: force counter to strong taken
//            upd_taken           taken: write tag/target and set valid
//            upd_idx/tag/tgt     update address and data
//  Revision: 1.0 - initial release
// ============================================================================
module bht_btb
    import pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output cnt_t             rd_cnt,
    output logic [XLEN-1:0]  rd_tgt,
    input  logic             upd_en,
    input  logic             upd_branch,
    input  logic             upd_jump,
    input  logic             upd_taken,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic [XLEN-1:0]  upd_tgt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic             w_valid_arr [ENTRIES];
    logic [TAG_W-1:0] w_tag_arr   [ENTRIES];
    cnt_t             w_cnt_arr   [ENTRIES];
    logic [XLEN-1:0]  w_tgt_arr   [ENTRIES];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic             r_valid;
        logic [TAG_W-1:0] r_tag;
        cnt_t             r_cnt;
        logic [XLEN-1:0]  r_tgt;
        logic             w_hit;

        assign w_hit = upd_en & (upd_idx == IDX_W'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_tag   <= '0;
                r_cnt   <= CNT_RESET;
                r_tgt   <= '0;
            end else if (w_hit) begin
                // A jump is always taken, so it saturates the counter outright.
                if (upd_jump) begin
                    r_cnt <= CNT_MAX;
                end else if (upd_branch) begin
                    r_cnt <= cnt_step(r_cnt, upd_taken);
                end
                if (upd_taken) begin
                    r_valid <= 1'b1;
                    r_tag   <= upd_tag;
                    r_tgt   <= upd_tgt;
                end
            end
        end

        assign w_valid_arr[i] = r_valid;
        assign w_tag_arr[i]   = r_tag;
        assign w_cnt_arr[i]   = r_cnt;
        assign w_tgt_arr[i]   = r_tgt;
    end

    assign rd_valid = w_valid_arr[rd_idx];
    assign rd_tag   = w_tag_arr[rd_idx];
    assign rd_cnt   = w_cnt_arr[rd_idx];
    assign rd_tgt   = w_tgt_arr[rd_idx];

endmodule
`default_nettype wire

// File: rtl/next_pc_predictor.sv
`default_nettype none
// ============================================================================
//  Module  : next_pc_predictor
//  Purpose : Fetch-stage PC generator with dynamic branch prediction.
//            Owns the PC register, predicts each fetch from a direct-mapped
//            BHT/BTB, resolves branch/JAL/JALR outcomes from EX, redirects
//            and flushes on mispredict, and handles ECALL/MRET redirects.
//  Ports   : clk, rst             clock, async active-high reset
//            stall                hold fetch PC (redirects override)
//            pc                   registered fetch PC
//            pred_taken/target    prediction for pc
//            ex_*                 resolved instruction info from EX
//            zero/less/less_unsigned  ALU compare flags
//            is_ecall/is_mret, mtvec/mepc  trap entry/return
//            flush                squash IF/ID (combinational)
//            mispredict_cnt       wrapping mispredict counter
//  Revision: 1.0 - initial release
// ============================================================================
module next_pc_predictor
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BHT_ENTRIES = 64,
    parameter int              TAG_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic            zero,
    input  logic            less,
    input  logic            less_unsigned,
    input  logic [XLEN-1:0] ex_branch_target,
    input  logic [XLEN-1:0] ex_jalr_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            is_ecall,
    input  logic            is_mret,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            flush,
    output logic [31:0]     mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0]  r_pc;
    logic [31:0]      r_mispredict_cnt;

    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    cnt_t             w_rd_cnt;
    logic [XLEN-1:0]  w_rd_tgt;

    logic             w_cond;
    logic             w_act_taken;
    logic [XLEN-1:0]  w_act_tgt;
    logic             w_mispredict;
    logic [XLEN-1:0]  w_pc_next;
    logic             w_upd_en;

    // JALR targets have bit 0 cleared, so that bit is never consumed.
    logic             w_unused_jalr_lsb;
    assign w_unused_jalr_lsb = ex_jalr_target[0];

    // ------------------------------------------------------------------
    // Prediction table
    // ------------------------------------------------------------------
    assign w_upd_en = ex_valid & ~is_ecall & ~is_mret;

    bht_btb #(
        .XLEN  (XLEN),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_bht_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (r_pc[IDX_W+1:2]),
        .rd_valid   (w_rd_valid),
        .rd_tag     (w_rd_tag),
        .rd_cnt     (w_rd_cnt),
        .rd_tgt     (w_rd_tgt),
        .upd_en     (w_upd_en),
        .upd_branch (ex_branch),
        .upd_jump   (ex_jump),
        .upd_taken  (w_act_taken),
        .upd_idx    (ex_pc[IDX_W+1:2]),
        .upd_tag    (ex_pc[IDX_W+2 +: TAG_W]),
        .upd_tgt    (w_act_tgt)
    );

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    assign pred_taken  = w_rd_valid & (w_rd_tag == r_pc[IDX_W+2 +: TAG_W]) & w_rd_cnt[1];
    assign pred_target = pred_taken ? w_rd_tgt : r_pc + XLEN'(4);

    // ------------------------------------------------------------------
    // Resolve
    // ------------------------------------------------------------------
    always_comb begin
        w_cond = 1'b0;
        case (ex_funct3)
            F3_BEQ:  w_cond = zero;
            F3_BNE:  w_cond = ~zero;
            F3_BLT:  w_cond = less;
            F3_BGE:  w_cond = ~less;
            F3_BLTU: w_cond = less_unsigned;
            F3_BGEU: w_cond = ~less_unsigned;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_act_taken = ex_jump | (ex_branch & w_cond);
    assign w_act_tgt   = (ex_jump & ex_jalr) ? {ex_jalr_target[XLEN-1:1], 1'b0}
                                             : ex_branch_target;

    // A correct taken prediction must also have the right target.
    assign w_mispredict = ex_valid & (ex_branch | ex_jump) &
                          ((w_act_taken != ex_pred_taken) |
                           (w_act_taken & (w_act_tgt != ex_pred_target)));

    assign flush = is_ecall | is_mret | w_mispredict;

    always_comb begin
        w_pc_next = pred_target;
        if (is_ecall) begin
            w_pc_next = mtvec;
        end else if (is_mret) begin
            w_pc_next = mepc;
        end else if (w_mispredict) begin
            w_pc_next = w_act_taken ? w_act_tgt : ex_pc + XLEN'(4);
        end else if (stall) begin
            w_pc_next = r_pc;
        end
    end

    // ------------------------------------------------------------------
    // PC register and mispredict counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc             <= RESET_PC;
            r_mispredict_cnt <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_mispredict) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign pc             = r_pc;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_next_pc_predictor.sv
`default_nettype none
// ============================================================================
//  Module  : tb_next_pc_predictor
//  Purpose : Self-checking bench for next_pc_predictor. A table of resolve
//            vectors (run with fetch stalled so the PC only moves on a
//            redirect) plus hand-written multi-cycle sequences for counter
//            training, saturation, JALR, traps, stall and aliasing.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_next_pc_predictor;
    import pc_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_jalr;
    logic [2:0]  ex_funct3;
    logic        zero;
    logic        less;
    logic        less_unsigned;
    logic [31:0] ex_branch_target;
    logic [31:0] ex_jalr_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        is_ecall;
    logic        is_mret;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        flush;
    logic [31:0] mispredict_cnt;

    next_pc_predictor #(
        .XLEN        (32),
        .RESET_PC    (32'h0000_0000),
        .BHT_ENTRIES (64),
        .TAG_W       (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .pc               (pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_branch        (ex_branch),
        .ex_jump          (ex_jump),
        .ex_jalr          (ex_jalr),
        .ex_funct3        (ex_funct3),
        .zero             (zero),
        .less             (less),
        .less_unsigned    (less_unsigned),
        .ex_branch_target (ex_branch_target),
        .ex_jalr_target   (ex_jalr_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .is_ecall         (is_ecall),
        .is_mret          (is_mret),
        .mtvec            (mtvec),
        .mepc             (mepc),
        .flush            (flush),
        .mispredict_cnt   (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] epc;
        logic [2:0]  f3;
        logic        br;
        logic        jp;
        logic        jr;
        logic        z;
        logic        l;
        logic        lu;
        logic [31:0] bt;
        logic [31:0] jt;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_flush;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [15];
    int   checks;
    int   errors;
    int   exp_mc;

    function automatic vec_t mk(input logic valid, input logic [31:0] epc, input logic [2:0] f3,
                                input logic br, input logic jp, input logic jr,
                                input logic z, input logic l, input logic lu,
                                input logic [31:0] bt, input logic [31:0] jt,
                                input logic pt, input logic [31:0] ptgt,
                                input logic e_flush, input logic [31:0] e_pc);
        vec_t v;
        v.valid = valid; v.epc = epc; v.f3 = f3; v.br = br; v.jp = jp; v.jr = jr;
        v.z = z; v.l = l; v.lu = lu; v.bt = bt; v.jt = jt; v.pt = pt; v.ptgt = ptgt;
        v.e_flush = e_flush; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        ex_valid         = v.valid;
        ex_pc            = v.epc;
        ex_funct3        = v.f3;
        ex_branch        = v.br;
        ex_jump          = v.jp;
        ex_jalr          = v.jr;
        zero             = v.z;
        less             = v.l;
        less_unsigned    = v.lu;
        ex_branch_target = v.bt;
        ex_jalr_target   = v.jt;
        ex_pred_taken    = v.pt;
        ex_pred_target   = v.ptgt;
    endtask

    task automatic clear_ex();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Steer fetch to addr with a mispredicted JAL at 0x80.
    task automatic redirect_to(input logic [31:0] addr);
        @(negedge clk);
        apply(mk(1, 32'h80, 3'b000, 0, 1, 0, 0, 0, 0, addr, 0, 0, 0, 1, addr));
        #1 chk("redirect_flush", {31'd0, flush}, 32'd1);
        @(posedge clk);
        #1 chk("redirect_pc", pc, addr);
        exp_mc++;
        clear_ex();
    endtask

    // Conditional branch at epc with explicit outcome flag and prediction.
    task automatic branch_ex(input logic [31:0] epc, input logic z, input logic [31:0] bt,
                             input logic pt, input logic [31:0] ptgt);
        apply(mk(1, epc, F3_BEQ, 1, 0, 0, z, 0, 0, bt, 0, pt, ptgt, 0, 0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_mc = 0;
        rst = 1'b1;
        stall = 1'b0;
        is_ecall = 1'b0;
        is_mret = 1'b0;
        mtvec = '0;
        mepc = '0;
        clear_ex();

        //                valid epc            f3      br jp jr z  l  lu bt            jt            pt ptgt          flush pc
        vecs[0]  = mk(1, 32'h200,       3'b000, 1, 0, 0, 1, 0, 0, 32'h300,      0,            0, 0,            1, 32'h300);
        vecs[1]  = mk(1, 32'h208,       3'b000, 1, 0, 0, 0, 0, 0, 32'h340,      0,            0, 0,            0, 32'h300);
        vecs[2]  = mk(1, 32'h210,       3'b001, 1, 0, 0, 0, 0, 0, 32'h380,      0,            1, 32'h380,      0, 32'h300);
        vecs[3]  = mk(1, 32'h218,       3'b001, 1, 0, 0, 1, 0, 0, 32'h3C0,      0,            1, 32'h3C0,      1, 32'h21C);
        vecs[4]  = mk(1, 32'h220,       3'b100, 1, 0, 0, 0, 1, 0, 32'h400,      0,            1, 32'h404,      1, 32'h400);
        vecs[5]  = mk(1, 32'h228,       3'b101, 1, 0, 0, 0, 1, 0, 32'h440,      0,            0, 0,            0, 32'h400);
        vecs[6]  = mk(1, 32'h230,       3'b110, 1, 0, 0, 0, 0, 1, 32'h480,      0,            0, 0,            1, 32'h480);
        vecs[7]  = mk(1, 32'h238,       3'b111, 1, 0, 0, 0, 1, 0, 32'h4C0,      0,            0, 0,            1, 32'h4C0);
        vecs[8]  = mk(1, 32'h240,       3'b010, 1, 0, 0, 1, 1, 1, 32'h500,      0,            1, 32'h500,      1, 32'h244);
        vecs[9]  = mk(1, 32'hFFFF_FFFC, 3'b000, 1, 0, 0, 0, 0, 0, 32'h10,       0,            1, 32'h10,       1, 32'h0);
        vecs[10] = mk(1, 32'h248,       3'b000, 0, 1, 0, 0, 0, 0, 32'h600,      0,            0, 0,            1, 32'h600);
        vecs[11] = mk(1, 32'h250,       3'b000, 0, 1, 1, 0, 0, 0, 32'h700,      32'h1235,     1, 32'h1234,     0, 32'h600);
        vecs[12] = mk(1, 32'h258,       3'b000, 0, 1, 1, 0, 0, 0, 32'h700,      32'h1235,     1, 32'h1235,     1, 32'h1234);
        vecs[13] = mk(0, 32'h260,       3'b000, 1, 0, 0, 1, 0, 0, 32'h700,      0,            0, 0,            0, 32'h1234);
        vecs[14] = mk(1, 32'h268,       3'b000, 0, 0, 0, 1, 0, 0, 32'h740,      0,            0, 0,            0, 32'h1234);

        // Reset held 3 cycles, then free-running fetch.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_pred", {31'd0, pred_taken}, 32'd0);
        chk("reset_mcnt", mispredict_cnt, 32'd0);
        @(posedge clk); #1 chk("seq_pc4", pc, 32'h4);
        chk("seq_pred4", {31'd0, pred_taken}, 32'd0);
        @(posedge clk); #1 chk("seq_pc8", pc, 32'h8);
        chk("seq_tgt8", pred_target, 32'hC);

        // Resolve table, fetch stalled.
        stall = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1 chk($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_flush});
            @(posedge clk);
            #1 chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
        end
        clear_ex();
        chk("table_mcnt", mispredict_cnt, 32'd9);

        // Asynchronous reset mid-run clears state without a clock edge.
        #2 rst = 1'b1;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_mcnt", mispredict_cnt, 32'd0);
        repeat (2) @(negedge clk);
        stall = 1'b0;
        rst = 1'b0;
        #1 chk("midrst_release_pc", pc, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        stall = 1'b1;
        chk("fetch_0x10", pc, 32'h10);
        chk("pred_0x10_cold", {31'd0, pred_taken}, 32'd0);

        // BEQ at 0x10 taken, predicted not-taken.
        @(negedge clk);
        branch_ex(32'h10, 1, 32'h40, 0, 0);
        #1 chk("beq_flush", {31'd0, flush}, 32'd1);
        @(posedge clk);
        #1 chk("beq_pc", pc, 32'h40);
        exp_mc++;
        clear_ex();
        redirect_to(32'h10);
        chk("beq_trained_pred", {31'd0, pred_taken}, 32'd1);
        chk("beq_trained_tgt", pred_target, 32'h40);

        // Loop branch taken 3x (correctly predicted), then exit.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            branch_ex(32'h10, 1, 32'h40, 1, 32'h40);
            #1 chk($sformatf("loop%0d_flush", k), {31'd0, flush}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        branch_ex(32'h10, 0, 32'h40, 1, 32'h40);
        #1 chk("loop_exit_flush", {31'd0, flush}, 32'd1);
        @(posedge clk);
        #1 chk("loop_exit_pc", pc, 32'h14);
        exp_mc++;
        clear_ex();
        redirect_to(32'h10);
        chk("loop_saturated_pred", {31'd0, pred_taken}, 32'd1);
        @(negedge clk);
        branch_ex(32'h10, 0, 32'h40, 1, 32'h40);
        @(posedge clk);
        #1 chk("loop_exit2_pc", pc, 32'h14);
        exp_mc++;
        clear_ex();
        redirect_to(32'h10);
        chk("loop_weak_pred", {31'd0, pred_taken}, 32'd0);
        chk("loop_weak_tgt", pred_target, 32'h14);

        // JALR with odd rs1+imm.
        @(negedge clk);
        apply(mk(1, 32'h300, 3'b000, 0, 1, 1, 0, 0, 0, 32'h999, 32'h1235, 0, 0, 0, 0));
        #1 chk("jalr_flush", {31'd0, flush}, 32'd1);
        @(posedge clk);
        #1 chk("jalr_pc", pc, 32'h1234);
        exp_mc++;
        clear_ex();
        redirect_to(32'h300);
        chk("jalr_btb_pred", {31'd0, pred_taken}, 32'd1);
        chk("jalr_btb_tgt", pred_target, 32'h1234);
        // One not-taken step from 3 still predicts taken.
        @(negedge clk);
        branch_ex(32'h300, 0, 32'h999, 1, 32'h1234);
        @(posedge clk);
        #1 chk("jalr_cnt_pc", pc, 32'h304);
        exp_mc++;
        clear_ex();
        redirect_to(32'h300);
        chk("jalr_cnt3_pred", {31'd0, pred_taken}, 32'd1);

        // ECALL with mispredict and stall: trap wins, no table update.
        @(negedge clk);
        branch_ex(32'h10, 1, 32'h40, 0, 0);
        is_ecall = 1'b1;
        mtvec = 32'h100;
        #1 chk("ecall_flush", {31'd0, flush}, 32'd1);
        @(posedge clk);
        #1 chk("ecall_pc", pc, 32'h100);
        exp_mc++;
        is_ecall = 1'b0;
        clear_ex();
        redirect_to(32'h10);
        chk("ecall_no_update", {31'd0, pred_taken}, 32'd0);
        @(negedge clk);
        is_mret = 1'b1;
        mepc = 32'h2C;
        #1 chk("mret_flush", {31'd0, flush}, 32'd1);
        @(posedge clk);
        #1 chk("mret_pc", pc, 32'h2C);
        is_mret = 1'b0;

        // Stall holds the PC.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 chk($sformatf("stall%0d_pc", k), pc, 32'h2C);
        end
        chk("stall_flush", {31'd0, flush}, 32'd0);

        // Mispredict during stall redirects; 0x400 aliases 0x300's index.
        redirect_to(32'h400);
        chk("alias_pred", {31'd0, pred_taken}, 32'd0);
        stall = 1'b0;
        @(posedge clk);
        #1 chk("alias_next_pc", pc, 32'h404);
        chk("final_mcnt", mispredict_cnt, exp_mc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
